font_row_reader: RTL
====================

Name: font_row_reader

Overview:
- Reader side of the font ROM interface: accepts a glyph/row request, drives the ROM port (`ce`, `oce`, `ad`), captures the 32-bit row word and serialises it MSB-first as a one-pixel-per-transfer stream to the video pixel pipeline.
- Sits between the character/text layer (issues requests) and the pixel mux.
- Glyph format: 32 rows x 32 pixels; ROM word address = {glyph, row}.

Parameters:
- DATA_W, 32, ROM word width = pixels per glyph row.
- ADDR_W, 8, ROM address width.
- ROW_W, 5, row index width; glyph index width = ADDR_W-ROW_W (3).
- ROM_LATENCY, 1, cycles from the ROM sampling `ce`/`ad` to valid `dout`: 1 = bypass mode, 2 = pipeline mode with `oce`.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  row request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_glyph  in  ADDR_W-ROW_W  glyph index.
- req_row  in  ROW_W  row within glyph.
- req_invert  in  1  invert all pixels of this row (cursor highlight).
- rom_ce  out  1  ROM clock enable.
- rom_oce  out  1  ROM output-register enable.
- rom_ad  out  ADDR_W  ROM word address.
- rom_dout  in  DATA_W  ROM read data.
- pix_valid  out  1  pixel valid.
- pix_ready  in  1  downstream accepts pixel.
- pix  out  1  pixel value (1 = foreground).
- pix_last  out  1  final pixel of the row.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock (`clk`); synchronous, active-high `reset`. All outputs are registered except `req_ready`, which is decoded from state.
- Reset values:
  - state IDLE, so `req_ready` = 1.
  - `pix_valid`, `pix`, `pix_last`, `rom_ce`, `busy` = 0; `rom_ad` = 0.
  - `rom_oce` = 1; it is held at 1 permanently.
  - Shift register, bit counter and prefetch buffer cleared.
- FSM: IDLE -> FETCH -> WAIT -> SHIFT.
  - IDLE: `req_ready`=1. On accept, latch invert, set `rom_ad`={req_glyph,req_row}, `rom_ce`=1, go to FETCH.
  - FETCH: exactly one cycle. The ROM samples at this edge; `rom_ce` deasserts at the same edge. Go to WAIT.
  - WAIT: ROM_LATENCY cycles (down-counter). On the final WAIT edge, shreg <= rom_dout XOR {DATA_W{invert}}, `pix_valid`<=1, go to SHIFT.
  - SHIFT: `pix`=shreg[DATA_W-1].
    - On each pix_valid && pix_ready: shift left by 1, increment counter.
    - `pix_last`=1 while the counter = DATA_W-1.
    - When the last pixel is accepted: go to IDLE with `pix_valid`=0 (base build).
- Latency: accept at edge E0 -> first `pix_valid` high after edge E(1+ROM_LATENCY), i.e. 2 cycles at default.
- Backpressure: while pix_valid && !pix_ready, `pix`, `pix_last` and shreg are held stable. No bit is lost or duplicated.
- `rom_ad` holds its last value when `rom_ce`=0.
- Reset mid-operation: abort at the reset edge; outputs return to reset values the next cycle; any partial row and buffered request are discarded.
- `req_valid` while `req_ready`=0: ignored. Requester must hold `req_valid` and the request fields stable until accepted.

Optional Feature:
- Macro: FONT_PREFETCH_EN.
- Defined:
  - `req_ready` is also high in SHIFT while the one-entry prefetch buffer is empty.
  - A request accepted in SHIFT runs its own FETCH/WAIT sequence in parallel; the result is stored in the prefetch buffer.
  - When the last pixel is accepted and the buffer is valid, the buffer loads shreg at that edge and `pix_valid` stays 1. Result: zero-bubble back-to-back rows.
  - If the buffered fetch is still in flight, SHIFT holds `pix_valid`=0 until the data lands.
- Undefined:
  - `req_ready` only in IDLE.
  - Gap between rows = 2+ROM_LATENCY cycles of `pix_valid`=0 with `req_valid` held high (3 at default).

Test Plan:
- ROM model addr 0x03 = 0x07FFF800; request glyph 0, row 3, invert 0, `pix_ready`=1 -> `rom_ce` high for 1 cycle with `rom_ad`=0x03. `pix_valid` rises 2 cycles after accept. Pixel sequence: 5x0, 16x1, 11x0. `pix_last` on pixel 32 only, then `req_ready`=1.
- Same request with invert 1 -> pixel sequence 5x1, 16x0, 11x1.
- Glyph 2, row 31 -> `rom_ad`=0x5F. `pix_ready` toggling 1,0,0,1 repeating -> 32 pixels exact, values stable during stalls, `pix_last` once.
- Reset asserted after 10 accepted pixels -> next cycle `pix_valid`=0, `busy`=0, `req_ready`=1, `rom_ce`=0. A subsequent request streams a full 32 pixels.
- ROM_LATENCY=2 model -> first `pix_valid` 3 cycles after accept; data correct.
- Two back-to-back requests (rows 3, 4) with `req_valid` held:
  - FONT_PREFETCH_EN defined -> 64 contiguous valid cycles, `pix_last` at 32 and 64.
  - Undefined -> exactly 3 idle cycles between rows.

Source files
------------

// File: rtl/font_row_reader.sv
// Font ROM row reader: fetches one 32-pixel glyph row and streams it MSB-first.
// Optional FONT_PREFETCH_EN adds a one-entry prefetch buffer for gapless rows.
module font_row_reader #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int ROW_W       = 5,
  parameter int ROM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-ROW_W-1:0] req_glyph,
  input  logic [ROW_W-1:0]        req_row,
  input  logic                    req_invert,
  output logic                    rom_ce,
  output logic                    rom_oce,
  output logic [ADDR_W-1:0]       rom_ad,
  input  logic [DATA_W-1:0]       rom_dout,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic                    pix,
  output logic                    pix_last,
  output logic                    busy
);

`ifdef FONT_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  localparam int CNT_W  = $clog2(DATA_W);
  localparam int WCNT_W = $clog2(ROM_LATENCY + 1);
  localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(ROM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_SHIFT} state_t;
  typedef enum logic [1:0] {PF_IDLE, PF_FETCH, PF_WAIT} pf_state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               inv_q, inv_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pix_valid_q, pix_valid_d;
  logic               pix_last_q, pix_last_d;
  logic               rom_ce_q, rom_ce_d;
  logic [ADDR_W-1:0]  rom_ad_q, rom_ad_d;
  logic               busy_q, busy_d;

  pf_state_t          pf_state_q, pf_state_d;
  logic [WCNT_W-1:0]  pf_cnt_q, pf_cnt_d;
  logic               pf_inv_q, pf_inv_d;
  logic [DATA_W-1:0]  pf_buf_q, pf_buf_d;
  logic               pf_valid_q, pf_valid_d;

  logic shift_fire, last_fire, pf_accept, pf_land;

  assign req_ready = (state_q == S_IDLE) ||
                     (PF_EN && state_q == S_SHIFT && pf_state_q == PF_IDLE && !pf_valid_q);
  assign rom_ce    = rom_ce_q;
  assign rom_oce   = 1'b1;
  assign rom_ad    = rom_ad_q;
  assign pix_valid = pix_valid_q;
  assign pix       = shreg_q[DATA_W-1];
  assign pix_last  = pix_last_q;
  assign busy      = busy_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    inv_d       = inv_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    rom_ce_d    = 1'b0;
    rom_ad_d    = rom_ad_q;
    pf_state_d  = pf_state_q;
    pf_cnt_d    = pf_cnt_q;
    pf_inv_d    = pf_inv_q;
    pf_buf_d    = pf_buf_q;
    pf_valid_d  = pf_valid_q;

    shift_fire = pix_valid_q && pix_ready;
    last_fire  = shift_fire && (cnt_q == CNT_W'(DATA_W - 1));
    pf_accept  = PF_EN && state_q == S_SHIFT && req_valid && req_ready;
    pf_land    = PF_EN && pf_state_q == PF_WAIT && pf_cnt_q == '0;

    // Prefetch fetch runs alongside SHIFT; the main FSM below may consume its
    // landing data directly and then overrides pf_valid_d.
    case (pf_state_q)
      PF_IDLE: begin
        if (pf_accept) begin
          pf_inv_d   = req_invert;
          rom_ad_d   = {req_glyph, req_row};
          rom_ce_d   = 1'b1;
          pf_state_d = PF_FETCH;
        end
      end
      PF_FETCH: begin
        pf_cnt_d   = WAIT_INIT;
        pf_state_d = PF_WAIT;
      end
      PF_WAIT: begin
        if (pf_cnt_q == '0) begin
          pf_buf_d   = rom_dout ^ {DATA_W{pf_inv_q}};
          pf_valid_d = 1'b1;
          pf_state_d = PF_IDLE;
        end else begin
          pf_cnt_d = pf_cnt_q - 1'b1;
        end
      end
      default: pf_state_d = PF_IDLE;
    endcase

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          inv_d    = req_invert;
          rom_ad_d = {req_glyph, req_row};
          rom_ce_d = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        wait_cnt_d = WAIT_INIT;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          shreg_d     = rom_dout ^ {DATA_W{inv_q}};
          cnt_d       = '0;
          pix_last_d  = 1'b0;
          pix_valid_d = 1'b1;
          state_d     = S_SHIFT;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      S_SHIFT: begin
        if (shift_fire) begin
          shreg_d    = shreg_q << 1;
          cnt_d      = cnt_q + 1'b1;
          pix_last_d = (cnt_q == CNT_W'(DATA_W - 2));
        end
        if (last_fire) begin
          cnt_d      = '0;
          pix_last_d = 1'b0;
          if (pf_valid_q) begin
            shreg_d    = pf_buf_q;
            pf_valid_d = 1'b0;
          end else if (pf_land) begin
            shreg_d    = rom_dout ^ {DATA_W{pf_inv_q}};
            pf_valid_d = 1'b0;
          end else if (pf_state_d != PF_IDLE) begin
            pix_valid_d = 1'b0;
          end else begin
            pix_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end else if (!pix_valid_q && pf_land) begin
          shreg_d     = rom_dout ^ {DATA_W{pf_inv_q}};
          cnt_d       = '0;
          pix_last_d  = 1'b0;
          pix_valid_d = 1'b1;
          pf_valid_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      inv_q       <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      rom_ce_q    <= 1'b0;
      rom_ad_q    <= '0;
      busy_q      <= 1'b0;
      pf_state_q  <= PF_IDLE;
      pf_cnt_q    <= '0;
      pf_inv_q    <= 1'b0;
      pf_buf_q    <= '0;
      pf_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      inv_q       <= inv_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      rom_ce_q    <= rom_ce_d;
      rom_ad_q    <= rom_ad_d;
      busy_q      <= busy_d;
      pf_state_q  <= pf_state_d;
      pf_cnt_q    <= pf_cnt_d;
      pf_inv_q    <= pf_inv_d;
      pf_buf_q    <= pf_buf_d;
      pf_valid_q  <= pf_valid_d;
    end
  end

endmodule
